// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the 16-bit ALU datapath: takes one instruction
// at a time, reads operands, drives ALU/multiplier/data memory and writes back.
module alu_issue_ctrl #(
    parameter int MUL_TIMEOUT = 32,
    parameter int DW          = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [4:0]      rf_raddr_a,
    output logic [4:0]      rf_raddr_b,
    input  logic [DW-1:0]   rf_rdata_a,
    input  logic [DW-1:0]   rf_rdata_b,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [3:0]      alu_sel,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    input  logic [DW-1:0]   alu_result,
    output logic            mul_start,
    input  logic            mul_done,
    input  logic [2*DW-1:0] mul_product,
    output logic [7:0]      dmem_addr,
    output logic            dmem_re,
    output logic            dmem_we,
    output logic [DW-1:0]   dmem_wdata,
    input  logic [DW-1:0]   dmem_rdata,
    output logic            busy,
    output logic            illegal_op,
    output logic            mul_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEMWAIT = 3'd3,
        MULWAIT = 3'd4,
        WB      = 3'd5,
        WB_HI   = 3'd6
    } state_t;

    localparam logic [5:0] OP_LDI      = 6'h00;
    localparam logic [5:0] OP_MOV      = 6'h01;
    localparam logic [5:0] OP_LD       = 6'h02;
    localparam logic [5:0] OP_ST       = 6'h03;
    localparam logic [5:0] OP_MUL      = 6'h07;
    localparam logic [5:0] OP_LAST_ALU = 6'h10;

    localparam int             CW       = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MUL_TIMEOUT - 1);

    state_t          state_r;
    logic [31:0]     ir_r;
    logic [CW-1:0]   cnt_r;
    logic [DW-1:0]   hi_r;
    logic [5:0]      op_s;
    logic            is_mul_s;

    assign op_s        = ir_r[31:26];
    assign is_mul_s    = (op_s == OP_MUL);
    assign rf_raddr_a  = ir_r[4:0];
    assign rf_raddr_b  = ir_r[9:5];
    assign instr_ready = (state_r == IDLE);

    // Instruction sequencer: all strobes default low and are raised for the single cycle they are needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ir_r       <= 32'h0000_0000;
            cnt_r      <= '0;
            hi_r       <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= '0;
            alu_sel    <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            mul_start  <= 1'b0;
            dmem_addr  <= 8'h00;
            dmem_re    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wdata <= '0;
            busy       <= 1'b0;
            illegal_op <= 1'b0;
            mul_err    <= 1'b0;
        end else begin
            rf_we      <= 1'b0;
            mul_start  <= 1'b0;
            dmem_re    <= 1'b0;
            dmem_we    <= 1'b0;
            illegal_op <= 1'b0;
            mul_err    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (instr_valid) begin
                        ir_r    <= instr;
                        busy    <= 1'b1;
                        state_r <= DECODE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DECODE: begin
                    case (op_s)
                        OP_LDI: begin
                            rf_wdata <= ir_r[15:0];
                            rf_waddr <= ir_r[25:21];
                            rf_we    <= 1'b1;
                            state_r  <= WB;
                        end
                        OP_MOV: begin
                            rf_wdata <= rf_rdata_a;
                            rf_waddr <= ir_r[25:21];
                            rf_we    <= 1'b1;
                            state_r  <= WB;
                        end
                        OP_LD: begin
                            dmem_addr <= ir_r[7:0];
                            dmem_re   <= 1'b1;
                            state_r   <= MEMWAIT;
                        end
                        OP_ST: begin
                            dmem_addr  <= ir_r[25:18];
                            dmem_wdata <= rf_rdata_a;
                            dmem_we    <= 1'b1;
                            busy       <= 1'b0;
                            state_r    <= IDLE;
                        end
                        OP_MUL: begin
                            alu_a     <= rf_rdata_b;
                            alu_b     <= rf_rdata_a;
                            alu_sel   <= 4'd3;
                            mul_start <= 1'b1;
                            cnt_r     <= '0;
                            state_r   <= MULWAIT;
                        end
                        default: begin
                            // Opcodes 0x04..0x10 map onto ALU functions 0..12; the
                            // 4-bit wrap makes 0x10 come out as 12.
                            if (op_s <= OP_LAST_ALU) begin
                                alu_a   <= rf_rdata_b;
                                alu_b   <= rf_rdata_a;
                                alu_sel <= op_s[3:0] - 4'd4;
                                state_r <= EXEC;
                            end else begin
                                illegal_op <= 1'b1;
                                busy       <= 1'b0;
                                state_r    <= IDLE;
                            end
                        end
                    endcase
                end
                EXEC: begin
                    rf_wdata <= alu_result;
                    rf_waddr <= ir_r[20:16];
                    rf_we    <= 1'b1;
                    state_r  <= WB;
                end
                MEMWAIT: begin
                    rf_wdata <= dmem_rdata;
                    rf_waddr <= ir_r[25:21];
                    rf_we    <= 1'b1;
                    state_r  <= WB;
                end
                MULWAIT: begin
                    // A result arriving on the last allowed cycle still counts.
                    if (mul_done) begin
                        rf_wdata <= mul_product[DW-1:0];
                        rf_waddr <= ir_r[20:16];
                        hi_r     <= mul_product[2*DW-1:DW];
                        rf_we    <= 1'b1;
                        state_r  <= WB;
                    end else if (cnt_r == CNT_LAST) begin
                        mul_err <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= MULWAIT;
                    end
                end
                WB: begin
                    if (is_mul_s) begin
                        rf_wdata <= hi_r;
                        rf_waddr <= ir_r[25:21];
                        rf_we    <= 1'b1;
                        state_r  <= WB_HI;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                WB_HI: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, multi-cycle
// corner sequences, then random instructions checked against a reference model.
module tb_alu_issue_ctrl;
    localparam int MUL_TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_init = 1'b1;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [3:0]  alu_sel;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        mul_start, mul_done;
    logic [31:0] mul_product;
    logic [7:0]  dmem_addr;
    logic        dmem_re, dmem_we;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic        busy, illegal_op, mul_err;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_TIMEOUT(MUL_TIMEOUT), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_sel(alu_sel), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result), .mul_start(mul_start), .mul_done(mul_done),
        .mul_product(mul_product), .dmem_addr(dmem_addr), .dmem_re(dmem_re),
        .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .busy(busy), .illegal_op(illegal_op), .mul_err(mul_err)
    );

    function automatic logic [15:0] alu_model(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            default: return a + b + {12'h000, sel};
        endcase
    endfunction

    function automatic logic [15:0] mem_init(input int i);
        return 16'(i * 251 + 17);
    endfunction

    // Environment: register file, data memory, ALU and a multiplier with programmable latency.
    logic [15:0] rf [32];
    logic [15:0] mem [256];
    int mul_lat = 0;
    int widx = 0;
    int acc_cnt = 0;

    assign rf_rdata_a  = rf[rf_raddr_a];
    assign rf_rdata_b  = rf[rf_raddr_b];
    assign dmem_rdata  = dmem_re ? mem[dmem_addr] : 16'h0000;
    assign alu_result  = alu_model(alu_sel, alu_a, alu_b);
    assign mul_product = {16'h0000, alu_a} * {16'h0000, alu_b};
    assign mul_done    = (mul_lat != 0) && (mul_start ? (mul_lat == 1) : (widx == mul_lat));

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 16'h0000;
            for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
            widx <= 0;
            acc_cnt <= 0;
        end else begin
            if (rf_we) rf[rf_waddr] <= rf_wdata;
            if (dmem_we) mem[dmem_addr] <= dmem_wdata;
            if (mul_start) widx <= 2;
            else if (mul_done) widx <= 0;
            else if (widx != 0) widx <= widx + 1;
            if (instr_valid && instr_ready) acc_cnt <= acc_cnt + 1;
        end
    end

    typedef struct {
        logic [31:0] iw;
        int          lat;
        int          cyc;
        int          nwr;
        logic [4:0]  wa0;
        logic [15:0] wd0;
        logic [4:0]  wa1;
        logic [15:0] wd1;
        int          ill;
        int          merr;
        int          ms;
        int          dwe;
        int          dre;
        logic [7:0]  daddr;
        logic [15:0] ddata;
    } vec_t;

    int errors = 0;
    int checks = 0;

    int          obs_cyc, obs_nwr, obs_ill, obs_merr, obs_ms, obs_dwe, obs_dre;
    logic [4:0]  obs_wa [2];
    logic [15:0] obs_wd [2];
    logic [7:0]  obs_daddr;
    logic [15:0] obs_ddata;

    logic [15:0] exp_rf [32];
    logic [15:0] exp_mem [256];
    logic [3:0]  exp_sel;
    logic [15:0] exp_a, exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_nwr = 0; obs_ill = 0; obs_merr = 0; obs_ms = 0; obs_dwe = 0; obs_dre = 0;
        obs_daddr = 8'h00; obs_ddata = 16'h0000;
        obs_wa[0] = 5'd0; obs_wa[1] = 5'd0; obs_wd[0] = 16'h0000; obs_wd[1] = 16'h0000;
    endtask

    task automatic sample();
        if (rf_we) begin
            if (obs_nwr < 2) begin
                obs_wa[obs_nwr] = rf_waddr;
                obs_wd[obs_nwr] = rf_wdata;
            end
            obs_nwr++;
        end
        if (illegal_op) obs_ill++;
        if (mul_err) obs_merr++;
        if (mul_start) obs_ms++;
        if (dmem_we) begin obs_dwe++; obs_daddr = dmem_addr; obs_ddata = dmem_wdata; end
        if (dmem_re) begin obs_dre++; obs_daddr = dmem_addr; end
    endtask

    // Called on the first falling edge after the accept edge; counts cycles until ready returns.
    task automatic wait_done();
        obs_cyc = 1;
        sample();
        while (!instr_ready && obs_cyc < 300) begin
            @(negedge clk);
            obs_cyc++;
            sample();
        end
    endtask

    task automatic run_instr(input logic [31:0] iw, input int lat);
        clear_obs();
        mul_lat = lat;
        @(negedge clk);
        chk("ready_before_issue", {31'h0, instr_ready}, 32'h1);
        instr = iw;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_done();
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        chk({tag, ".cycles"}, obs_cyc, e.cyc);
        chk({tag, ".nwr"}, obs_nwr, e.nwr);
        if (e.nwr >= 1 && obs_nwr >= 1) begin
            chk({tag, ".waddr0"}, obs_wa[0], e.wa0);
            chk({tag, ".wdata0"}, obs_wd[0], e.wd0);
        end
        if (e.nwr >= 2 && obs_nwr >= 2) begin
            chk({tag, ".waddr1"}, obs_wa[1], e.wa1);
            chk({tag, ".wdata1"}, obs_wd[1], e.wd1);
        end
        chk({tag, ".illegal"}, obs_ill, e.ill);
        chk({tag, ".mul_err"}, obs_merr, e.merr);
        chk({tag, ".mul_start"}, obs_ms, e.ms);
        chk({tag, ".dmem_we"}, obs_dwe, e.dwe);
        chk({tag, ".dmem_re"}, obs_dre, e.dre);
        if (e.dwe + e.dre > 0) chk({tag, ".dmem_addr"}, obs_daddr, e.daddr);
        if (e.dwe > 0) chk({tag, ".dmem_wdata"}, obs_ddata, e.ddata);
    endtask

    // Reference model: architectural effect and latency of one instruction.
    task automatic model_exec(input logic [31:0] iw, input int lat, output vec_t e);
        logic [5:0]  op;
        logic [4:0]  rd2, rd1, rs2, rs1;
        logic [31:0] p;
        op  = iw[31:26]; rd2 = iw[25:21]; rd1 = iw[20:16]; rs2 = iw[9:5]; rs1 = iw[4:0];
        e = '{default: 0};
        e.iw = iw;
        e.lat = lat;
        if (op == 6'd0) begin
            e.cyc = 3; e.nwr = 1; e.wa0 = rd2; e.wd0 = iw[15:0];
        end else if (op == 6'd1) begin
            e.cyc = 3; e.nwr = 1; e.wa0 = rd2; e.wd0 = exp_rf[rs1];
        end else if (op == 6'd2) begin
            e.cyc = 4; e.nwr = 1; e.wa0 = rd2; e.wd0 = exp_mem[iw[7:0]];
            e.dre = 1; e.daddr = iw[7:0];
        end else if (op == 6'd3) begin
            e.cyc = 2; e.dwe = 1; e.daddr = iw[25:18]; e.ddata = exp_rf[rs1];
            exp_mem[iw[25:18]] = exp_rf[rs1];
        end else if (op == 6'd7) begin
            exp_sel = 4'd3; exp_a = exp_rf[rs2]; exp_b = exp_rf[rs1];
            e.ms = 1;
            if (lat >= 1 && lat <= MUL_TIMEOUT) begin
                p = exp_a * exp_b;
                e.cyc = 4 + lat; e.nwr = 2;
                e.wa0 = rd1; e.wd0 = p[15:0];
                e.wa1 = rd2; e.wd1 = p[31:16];
            end else begin
                e.cyc = 2 + MUL_TIMEOUT; e.merr = 1;
            end
        end else if (op <= 6'd16) begin
            exp_sel = 4'(op - 6'd4); exp_a = exp_rf[rs2]; exp_b = exp_rf[rs1];
            e.cyc = 4; e.nwr = 1; e.wa0 = rd1; e.wd0 = alu_model(exp_sel, exp_a, exp_b);
        end else begin
            e.cyc = 2; e.ill = 1;
        end
        if (e.nwr >= 1) exp_rf[e.wa0] = e.wd0;
        if (e.nwr >= 2) exp_rf[e.wa1] = e.wd1;
    endtask

    task automatic check_alu_regs(input string tag);
        chk({tag, ".alu_sel"}, alu_sel, exp_sel);
        chk({tag, ".alu_a"}, alu_a, exp_a);
        chk({tag, ".alu_b"}, alu_b, exp_b);
    endtask

    vec_t tbl [17];
    vec_t e;

    initial begin
        int          wcnt, acc0, mism;
        logic [31:0] iw;
        logic [5:0]  op;
        int          lat, cls;

        //           iw            lat cyc nwr wa0    wd0        wa1    wd1        ill merr ms dwe dre daddr  ddata
        tbl[0]  = '{32'h0060_1234, 0,  3,  1, 5'd3,  16'h1234, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[1]  = '{32'h0020_0007, 0,  3,  1, 5'd1,  16'h0007, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[2]  = '{32'h0040_0009, 0,  3,  1, 5'd2,  16'h0009, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[3]  = '{32'h1005_0022, 0,  4,  1, 5'd5,  16'h0010, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[4]  = '{32'h0500_0003, 0,  3,  1, 5'd8,  16'h1234, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[5]  = '{32'h0140_1234, 0,  3,  1, 5'd10, 16'h1234, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[6]  = '{32'h0160_0100, 0,  3,  1, 5'd11, 16'h0100, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[7]  = '{32'h0180_BEEF, 0,  3,  1, 5'd12, 16'hBEEF, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[8]  = '{32'h1C86_014B, 5,  9,  2, 5'd6,  16'h3400, 5'd4,  16'h0012, 0,  0,  1, 0,  0, 8'h00, 16'h0000};
        tbl[9]  = '{32'h1C86_014B, 0,  34, 0, 5'd0,  16'h0000, 5'd0,  16'h0000, 0,  1,  1, 0,  0, 8'h00, 16'h0000};
        tbl[10] = '{32'h1C84_014B, 32, 36, 2, 5'd4,  16'h3400, 5'd4,  16'h0012, 0,  0,  1, 0,  0, 8'h00, 16'h0000};
        tbl[11] = '{32'h0CA8_000C, 0,  2,  0, 5'd0,  16'h0000, 5'd0,  16'h0000, 0,  0,  0, 1,  0, 8'h2A, 16'hBEEF};
        tbl[12] = '{32'h08E0_002A, 0,  4,  1, 5'd7,  16'hBEEF, 5'd0,  16'h0000, 0,  0,  0, 0,  1, 8'h2A, 16'h0000};
        tbl[13] = '{32'h5400_0000, 0,  2,  0, 5'd0,  16'h0000, 5'd0,  16'h0000, 1,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[14] = '{32'hFC00_0000, 0,  2,  0, 5'd0,  16'h0000, 5'd0,  16'h0000, 1,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[15] = '{32'h4009_0022, 0,  4,  1, 5'd9,  16'h001C, 5'd0,  16'h0000, 0,  0,  0, 0,  0, 8'h00, 16'h0000};
        tbl[16] = '{32'h4400_0000, 0,  2,  0, 5'd0,  16'h0000, 5'd0,  16'h0000, 1,  0,  0, 0,  0, 8'h00, 16'h0000};

        for (int i = 0; i < 32; i++) exp_rf[i] = 16'h0000;
        for (int i = 0; i < 256; i++) exp_mem[i] = mem_init(i);
        exp_sel = 4'd0; exp_a = 16'h0000; exp_b = 16'h0000;

        instr_valid = 1'b0;
        instr = 32'h0000_0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tb_init = 1'b0;
        @(negedge clk);
        chk("rst.instr_ready", {31'h0, instr_ready}, 32'h1);
        chk("rst.busy", {31'h0, busy}, 32'h0);
        chk("rst.rf_we", {31'h0, rf_we}, 32'h0);
        chk("rst.rf_wdata", rf_wdata, 32'h0);
        chk("rst.strobes", {dmem_re, dmem_we, mul_start, illegal_op, mul_err}, 32'h0);
        chk("rst.dmem_addr", dmem_addr, 32'h0);
        check_alu_regs("rst");

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            run_instr(tbl[i].iw, tbl[i].lat);
            check_vec($sformatf("tbl%0d", i), tbl[i]);
            model_exec(tbl[i].iw, tbl[i].lat, e);
            check_alu_regs($sformatf("tbl%0d", i));
            if (i == 3 || i == 4) begin
                chk($sformatf("add%0d.alu_sel", i), alu_sel, 32'h0);
                chk($sformatf("add%0d.alu_a", i), alu_a, 32'h7);
                chk($sformatf("add%0d.alu_b", i), alu_b, 32'h9);
            end
        end

        // Reset while the multiplier is outstanding: nothing may be written
        mul_lat = 0;
        wcnt = 0;
        @(negedge clk);
        instr = 32'h1C86_014B;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rf_we) wcnt++;
        end
        chk("rstmul.busy_before", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        if (rf_we) wcnt++;
        rst_n = 1'b1;
        chk("rstmul.busy_after", {31'h0, busy}, 32'h0);
        chk("rstmul.ready_after", {31'h0, instr_ready}, 32'h1);
        repeat (3) begin
            @(negedge clk);
            if (rf_we || mul_err) wcnt++;
        end
        chk("rstmul.no_write", wcnt, 32'h0);
        exp_sel = 4'd0; exp_a = 16'h0000; exp_b = 16'h0000;
        check_alu_regs("rstmul");

        // instr_valid held high across two back-to-back instructions
        acc0 = acc_cnt;
        clear_obs();
        mul_lat = 0;
        @(negedge clk);
        instr = 32'h01A0_A5A5;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr = 32'h01C0_5A5A;
        wait_done();
        model_exec(32'h01A0_A5A5, 0, e);
        check_vec("b2b_first", e);
        clear_obs();
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_done();
        model_exec(32'h01C0_5A5A, 0, e);
        check_vec("b2b_second", e);
        chk("b2b.accepts", acc_cnt - acc0, 32'h2);

        // Random instructions against the reference model
        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 6);
            lat = 0;
            case (cls)
                0: op = 6'h00;
                1: op = 6'h01;
                2: op = 6'h02;
                3: op = 6'h03;
                4: begin
                    op = 6'($urandom_range(4, 15));
                    if (op == 6'h07) op = 6'h10;
                end
                5: begin
                    op = 6'h07;
                    lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
                end
                default: op = 6'($urandom_range(17, 63));
            endcase
            iw = $urandom;
            iw[31:26] = op;
            model_exec(iw, lat, e);
            run_instr(iw, lat);
            check_vec($sformatf("rnd%0d_%08h", n, iw), e);
            check_alu_regs($sformatf("rnd%0d", n));
        end

        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== exp_rf[i]) mism++;
        chk("final_rf_mismatches", mism, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
